// File: rtl/viterbi_link_ctrl.sv
// viterbi_link_ctrl: frame sequencer for encoder->channel->Viterbi loopback with error injection and bit-error count
module viterbi_link_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL = 8,
  parameter int DEC_LAT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [15:0]      seed_i,
  input  logic             err_en_i,
  input  logic [7:0]       err_period_i,
  input  logic [1:0]       err_mask_i,
  output logic             enc_en_o,
  output logic             enc_bit_o,
  input  logic             enc_valid_i,
  input  logic [1:0]       enc_sym_i,
  output logic [1:0]       chan_sym_o,
  output logic             dec_en_o,
  input  logic             dec_bit_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] inj_count_o,
  output logic [CNT_W-1:0] bit_err_o
);
  localparam int PW = $clog2(FRAME_LEN + TAIL + DEC_LAT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, FLUSH, DRAIN, DONE} state_t;
  state_t st, nxt;
  logic [PW-1:0] ph;
  logic [15:0] lfsr;
  logic [7:0] sym_ct;
  logic [DEC_LAT-1:0] dl_bit, dl_tag;
  logic last, cnt_v, hit, inj, tap_err;
  int lim;
  // next state, phase-end detection and Moore outputs
  always_comb begin
    lim = st == SEND ? FRAME_LEN : st == FLUSH ? TAIL : DEC_LAT;
    last = ph == PW'(lim - 1);
    nxt = st;
    if (st == IDLE && start_i) nxt = LOAD;
    else if (st == LOAD) nxt = SEND;
    else if (st == SEND && last) nxt = FLUSH;
    else if (st == FLUSH && last) nxt = DRAIN;
    else if (st == DRAIN && last) nxt = DONE;
    else if (st == DONE) nxt = IDLE;
    enc_en_o = st == SEND || st == FLUSH;
    enc_bit_o = st == SEND && lfsr[0];
    busy_o = st != IDLE;
    done_o = st == DONE;
    cnt_v = busy_o && enc_valid_i;
    hit = sym_ct == err_period_i - 8'd1;
    inj = err_en_i && err_period_i != 8'd0 && cnt_v && hit;
    tap_err = dl_tag[DEC_LAT-1] && (dl_bit[DEC_LAT-1] ^ dec_bit_i);
  end
  // state register and per-state phase counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      ph <= '0;
    end else begin
      st <= nxt;
      ph <= (nxt != st || st == IDLE) ? '0 : ph + 1'b1;
    end
  end
  // payload LFSR: seeded in LOAD, advanced once per payload bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= '0;
    else if (st == LOAD) lfsr <= seed_i == 16'd0 ? 16'hACE1 : seed_i;
    else if (st == SEND) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  // channel stage: register symbols toward the decoder, corrupting the selected ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_en_o <= 1'b0;
      chan_sym_o <= '0;
    end else begin
      dec_en_o <= enc_valid_i;
      chan_sym_o <= enc_sym_i ^ (inj ? err_mask_i : 2'b00);
    end
  end
  // valid-symbol counter wrapping at the injection period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sym_ct <= '0;
    else if (st == LOAD) sym_ct <= '0;
    else if (cnt_v) sym_ct <= hit ? '0 : sym_ct + 8'd1;
  end
  // reference delay line matched to decoder latency; tag marks payload bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_bit <= '0;
      dl_tag <= '0;
    end else begin
      dl_bit <= (dl_bit << 1) | DEC_LAT'(enc_bit_o);
      dl_tag <= (dl_tag << 1) | DEC_LAT'(st == SEND);
    end
  end
  // saturating result counters, cleared at frame load and held while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_count_o <= '0;
      bit_err_o <= '0;
    end else if (st == LOAD) begin
      inj_count_o <= '0;
      bit_err_o <= '0;
    end else begin
      inj_count_o <= (inj && !(&inj_count_o)) ? inj_count_o + 1'b1 : inj_count_o;
      bit_err_o <= (tap_err && !(&bit_err_o)) ? bit_err_o + 1'b1 : bit_err_o;
    end
  end
endmodule
